// File: rtl/proc_hdr_serializer_pkg.sv
// Shared widths and types for the processor output path: byte bus, header
// container, egress port count and the serializer state encoding.
package proc_hdr_serializer_pkg;

    localparam int BYTE_BUS    = 8;
    localparam int HDR_MAX_LEN = 8;
    localparam int NUM_PORTS   = 4;

    typedef logic [BYTE_BUS-1:0]     byte_t;
    typedef byte_t [HDR_MAX_LEN-1:0] hdr_t;   // byte 0 sits in the low bits
    typedef logic [NUM_PORTS-1:0]    port_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/proc_drop_counter.sv
// Free-running wrap-around event counter with a single increment enable.
module proc_drop_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_hdr_serializer.sv
// Reader side of the one-entry processor output latch: pops a header and its
// port mask, then streams it one byte per beat with SOP/EOP framing.
module proc_hdr_serializer
    import proc_hdr_serializer_pkg::*;
#(
    parameter int HDR_LEN = HDR_MAX_LEN,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty_i,
    input  hdr_t                 pkt_hdr_i,
    input  port_t                out_port_i,
    output logic                 rd_o,
    output logic                 tx_valid_o,
    output byte_t                tx_data_o,
    output logic                 tx_sop_o,
    output logic                 tx_eop_o,
    output port_t                tx_port_o,
    input  port_t                tx_ready_i,
    output logic [CNT_W-1:0]     drop_cnt_o
);

    localparam int IDX_W = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;

    ser_state_e                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    byte_t [HDR_LEN-1:0]       hdr_q, hdr_d;
    port_t                     port_q, port_d;
    logic                      drop_inc;
    logic                      xfer;
    logic                      load;
    logic                      unused_hdr_bits;

    // Bytes at or beyond HDR_LEN are never captured.
    assign unused_hdr_bits = ^pkt_hdr_i;

    // Every selected port must accept in the same cycle; unselected ports are masked.
    assign xfer = tx_valid_o && (&(tx_ready_i | ~tx_port_o));
    assign load = !empty_i && ((state_q == IDLE) || (xfer && tx_eop_o));
    assign rd_o = load;

    // NOTE: the captured header is reset along with the control state so that
    // tx_data_o reads zero out of reset; it is a handful of flops, not a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hdr_q   <= '0;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            port_q  <= port_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hdr_d    = hdr_q;
        port_d   = port_q;
        drop_inc = 1'b0;
        if (load) begin
            idx_d = '0;
            if (out_port_i != '0) begin
                hdr_d   = pkt_hdr_i[HDR_LEN-1:0];
                port_d  = out_port_i;
                state_d = SEND;
            end else begin
                drop_inc = 1'b1;
                state_d  = IDLE;
            end
        end else if (xfer) begin
            if (tx_eop_o) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        tx_valid_o = (state_q == SEND);
        tx_sop_o   = tx_valid_o && (idx_q == '0);
        tx_eop_o   = tx_valid_o && (idx_q == IDX_W'(HDR_LEN - 1));
        tx_port_o  = tx_valid_o ? port_q : '0;
        tx_data_o  = '0;
        for (int i = 0; i < HDR_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                tx_data_o = hdr_q[i];
            end
        end
    end

    proc_drop_counter #(
        .CNT_W (CNT_W)
    ) u_drop_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt_o)
    );

endmodule
